// File: rtl/wsg_nch.sv
// wsg_nch: multi-channel wavetable sound generator.
// Once per sample period the channels are visited in turn (fetch a ROM sample,
// wait for the data, accumulate the scaled contribution and advance the phase).
// The saturated mix is then presented on SOUT together with a one-cycle strobe.
module wsg_nch #(
   parameter int NCH    = 8,
   parameter int FW     = 20,
   parameter int WW     = 4,
   parameter int VW     = 4,
   parameter int OW     = 8,
   parameter int CLKDIV = 1000
) (
   input  logic                   CLK24M,
   input  logic                   RESET,
   input  logic [$clog2(NCH)+2:0] ADDR,
   input  logic [7:0]             DATA,
   input  logic                   WE,
   input  logic                   SND_ENABLE,
   output logic [7:0]             WAVE_AD,
   output logic                   WAVE_RD,
   input  logic [WW-1:0]          WAVE_DT,
   output logic [OW-1:0]          SOUT,
   output logic                   SAMPLE_STB
);

   localparam int CW = $clog2(NCH);
   localparam int SW = WW + CW;
   localparam int DW = $clog2(CLKDIV);
   localparam int PW = WW + VW;
   localparam logic [31:0] OMAX = (32'd1 << OW) - 32'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ACC,
      S_OUT
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic [SW-1:0]   sum_q, sum_d;
   logic [WW-1:0]   sample_q, sample_d;
   logic [14:0]     lfsr_q, lfsr_d;
   logic [OW-1:0]   sout_q, sout_d;
   logic            stb_q, stb_d;
   logic            tick;

   // Per-channel views used by the sequencer, indexed by the current channel.
   logic [VW-1:0]   vol_a   [NCH];
   logic [2:0]      wsel_a  [NCH];
   logic            noise_a [NCH];
   logic            fzero_a [NCH];
   logic [4:0]      ptop_a  [NCH];

   // DATA[7] has no register field; kept visible so the bit is consumed.
   logic            unused_data;
   assign unused_data = DATA[7];

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [VW-1:0] vol_q, vol_d;
      logic [FW-1:0] freq_q, freq_d;
      logic [2:0]    wsel_q, wsel_d;
      logic          noise_q, noise_d;
      logic [FW-1:0] c_q, c_d;
      logic          sel;

      assign sel         = WE && (ADDR[CW+2:3] == CW'(gi));
      assign vol_a[gi]   = vol_q;
      assign wsel_a[gi]  = wsel_q;
      assign noise_a[gi] = noise_q;
      assign fzero_a[gi] = (freq_q == '0);
      assign ptop_a[gi]  = c_q[FW-1 -: 5];

      // Register writes land immediately; the phase advances only in this channel's ACC slot.
      always_comb begin
         vol_d   = vol_q;
         freq_d  = freq_q;
         wsel_d  = wsel_q;
         noise_d = noise_q;
         c_d     = c_q;
         if (sel) begin
            case (ADDR[2:0])
               3'd3: vol_d = DATA[VW-1:0];
               3'd4: freq_d[7:0] = DATA;
               3'd5: freq_d[15:8] = DATA;
               3'd6: begin
                  freq_d[FW-1:16] = DATA[FW-17:0];
                  wsel_d          = DATA[6:4];
               end
               3'd7: noise_d = DATA[0];
               default: ;
            endcase
         end
         if ((state_q == S_ACC) && (ch_q == CW'(gi))) begin
            c_d = c_q + freq_q;
         end
      end

      // Channel register and phase accumulator storage.
      always_ff @(posedge CLK24M or posedge RESET) begin
         if (RESET) begin
            vol_q   <= '0;
            freq_q  <= '0;
            wsel_q  <= '0;
            noise_q <= 1'b0;
            c_q     <= '0;
         end else begin
            vol_q   <= vol_d;
            freq_q  <= freq_d;
            wsel_q  <= wsel_d;
            noise_q <= noise_d;
            c_q     <= c_d;
         end
      end
   end

   // Contribution of the current channel: top WW bits of sample*volume.
   logic [WW-1:0]  smp;
   logic [PW-1:0]  prod;
   logic [WW-1:0]  contrib;
   logic [SW:0]    dbl;
   logic [OW-1:0]  sat;

   assign smp     = noise_a[ch_q] ? {WW{lfsr_q[0]}} : sample_q;
   assign prod    = PW'(smp) * PW'(vol_a[ch_q]);
   assign contrib = fzero_a[ch_q] ? '0 : WW'(prod >> VW);
   assign dbl     = {sum_q, 1'b0};
   assign sat     = (32'(dbl) > OMAX) ? OW'(OMAX) : OW'(dbl);
   assign tick    = (cnt_q == DW'(CLKDIV - 1));

   // Sequencer next-state, ROM interface and mix/output computation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = tick ? '0 : cnt_q + DW'(1);
      ch_d     = ch_q;
      sum_d    = sum_q;
      sample_d = sample_q;
      lfsr_d   = lfsr_q;
      sout_d   = sout_q;
      stb_d    = 1'b0;
      WAVE_AD  = 8'd0;
      WAVE_RD  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_FETCH;
               ch_d    = '0;
               sum_d   = '0;
            end
         end
         S_FETCH: begin
            WAVE_AD = {wsel_a[ch_q], ptop_a[ch_q]};
            WAVE_RD = !noise_a[ch_q];
            state_d = S_WAIT;
         end
         S_WAIT: begin
            sample_d = WAVE_DT;
            state_d  = S_ACC;
         end
         S_ACC: begin
            sum_d = sum_q + SW'(contrib);
            if (ch_q == CW'(NCH - 1)) begin
               state_d = S_OUT;
            end else begin
               ch_d    = ch_q + CW'(1);
               state_d = S_FETCH;
            end
         end
         S_OUT: begin
            sout_d  = SND_ENABLE ? sat : '0;
            stb_d   = 1'b1;
            lfsr_d  = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer, divider, mix and output registers.
   always_ff @(posedge CLK24M or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ch_q     <= '0;
         sum_q    <= '0;
         sample_q <= '0;
         lfsr_q   <= 15'h0001;
         sout_q   <= '0;
         stb_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ch_q     <= ch_d;
         sum_q    <= sum_d;
         sample_q <= sample_d;
         lfsr_q   <= lfsr_d;
         sout_q   <= sout_d;
         stb_q    <= stb_d;
      end
   end

   assign SOUT       = sout_q;
   assign SAMPLE_STB = stb_q;

endmodule

// File: tb/tb_wsg_nch.sv
// tb_wsg_nch: directed, table-driven bench for wsg_nch (8-channel instance plus a
// 16-channel instance for the saturation case).
module tb_wsg_nch;

   localparam int NCH      = 8;
   localparam int CLKDIV   = 40;
   localparam int CLKDIV16 = 60;
   localparam int RST_LAT  = CLKDIV + 3*NCH + 1;

   typedef struct {
      int vol;
      int rom;
      int freq;
      int exp;
   } vec_t;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic [5:0] addr    = '0;
   logic [7:0] data    = '0;
   logic       we      = 1'b0;
   logic       snd_en  = 1'b1;
   logic [7:0] wave_ad;
   logic       wave_rd;
   logic [3:0] wave_dt = '0;
   logic [7:0] sout;
   logic       stb;
   logic [3:0] rom_val = 4'd15;

   logic [6:0] addr16    = '0;
   logic       we16      = 1'b0;
   logic [7:0] wave_ad16;
   logic       wave_rd16;
   logic [3:0] wave_dt16 = '0;
   logic [7:0] sout16;
   logic       stb16;

   int         total    = 0;
   int         bad      = 0;
   int         rd_cnt   = 0;
   int         pass_rd  = 0;
   logic [7:0] ad0      = '0;
   logic [7:0] pass_ad0 = '0;

   wsg_nch #(.NCH(NCH), .FW(20), .WW(4), .VW(4), .OW(8), .CLKDIV(CLKDIV)) dut (
      .CLK24M(clk), .RESET(rst), .ADDR(addr), .DATA(data), .WE(we),
      .SND_ENABLE(snd_en), .WAVE_AD(wave_ad), .WAVE_RD(wave_rd),
      .WAVE_DT(wave_dt), .SOUT(sout), .SAMPLE_STB(stb)
   );

   wsg_nch #(.NCH(16), .FW(20), .WW(4), .VW(4), .OW(8), .CLKDIV(CLKDIV16)) dut16 (
      .CLK24M(clk), .RESET(rst), .ADDR(addr16), .DATA(data), .WE(we16),
      .SND_ENABLE(snd_en), .WAVE_AD(wave_ad16), .WAVE_RD(wave_rd16),
      .WAVE_DT(wave_dt16), .SOUT(sout16), .SAMPLE_STB(stb16)
   );

   always #5 clk = ~clk;

   // Wave ROMs: data valid one cycle after the read strobe.
   always @(posedge clk) if (wave_rd) wave_dt <= rom_val;
   always @(posedge clk) if (wave_rd16) wave_dt16 <= 4'd15;

   // Count reads in the current pass and remember the first (channel 0) address.
   always @(negedge clk) begin
      if (wave_rd) begin
         if (rd_cnt == 0) ad0 = wave_ad;
         rd_cnt = rd_cnt + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("check %s: got %0d ok", name, act);
      end
   endtask

   task automatic wr(input int ch, input int r, input int val);
      addr = 6'((ch << 3) | r);
      data = 8'(val);
      we   = 1'b1;
      @(negedge clk);
      we   = 1'b0;
   endtask

   task automatic wr16(input int ch, input int r, input int val);
      addr16 = 7'((ch << 3) | r);
      data   = 8'(val);
      we16   = 1'b1;
      @(negedge clk);
      we16   = 1'b0;
   endtask

   task automatic set_ch(input int ch, input int vol, input int freq, input int wsel, input int noise);
      wr(ch, 3, vol);
      wr(ch, 4, freq & 255);
      wr(ch, 5, (freq >> 8) & 255);
      wr(ch, 6, ((wsel & 7) << 4) | ((freq >> 16) & 15));
      wr(ch, 7, noise);
   endtask

   task automatic wait_stb();
      int n;
      n = 0;
      @(negedge clk);
      while (!stb && n < 4*CLKDIV) begin
         @(negedge clk);
         n++;
      end
      if (!stb) begin
         total++;
         bad++;
         $display("FAIL stb_timeout: no strobe within %0d cycles, expected one", 4*CLKDIV);
      end
      pass_rd  = rd_cnt;
      pass_ad0 = ad0;
      rd_cnt   = 0;
   endtask

   task automatic wait_stb16();
      int n;
      n = 0;
      @(negedge clk);
      while (!stb16 && n < 4*CLKDIV16) begin
         @(negedge clk);
         n++;
      end
      if (!stb16) begin
         total++;
         bad++;
         $display("FAIL stb16_timeout: no strobe within %0d cycles, expected one", 4*CLKDIV16);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst    = 1'b1;
      we     = 1'b0;
      we16   = 1'b0;
      snd_en = 1'b1;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      rd_cnt = 0;
   endtask

   initial begin
      vec_t        vecs [9];
      int          k;
      int          n;
      logic [14:0] lf;

      vecs[0] = '{15, 15, 'h08000, 28};
      vecs[1] = '{15,  8, 1,       14};
      vecs[2] = '{ 5, 15, 1,        8};
      vecs[3] = '{15,  0, 1,        0};
      vecs[4] = '{ 0, 15, 1,        0};
      vecs[5] = '{15, 15, 0,        0};
      vecs[6] = '{ 8,  9, 'h00300,  8};
      vecs[7] = '{ 1, 15, 1,        0};
      vecs[8] = '{ 9, 13, 'h12345, 14};

      // Reset state
      #2 rst = 1'b1;
      #1;
      check("rst_sout", sout, 0);
      check("rst_stb", stb, 0);
      check("rst_rd", wave_rd, 0);
      check("rst_ad", wave_ad, 0);
      check("rst_sout16", sout16, 0);
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      rd_cnt = 0;

      // All channels silent (freq 0) even with full volume
      for (int c = 0; c < NCH; c++) wr(c, 3, 15);
      for (int p = 0; p < 3; p++) begin
         wait_stb();
         check("zero_sout", sout, 0);
         check("zero_phase", pass_ad0, 0);
         check("zero_reads", pass_rd, NCH);
      end

      // Single-channel contribution table
      for (int i = 0; i < 9; i++) begin
         set_ch(0, vecs[i].vol, vecs[i].freq, 0, 0);
         rom_val = 4'(vecs[i].rom);
         wait_stb();
         check($sformatf("vec%0d_sout", i), sout, vecs[i].exp);
      end

      // All eight channels at full scale
      for (int c = 0; c < NCH; c++) set_ch(c, 15, 256*(c+1), c, 0);
      rom_val = 4'd15;
      wait_stb();
      wait_stb();
      for (int p = 0; p < 2; p++) begin
         wait_stb();
         check("all8_sout", sout, 224);
         check("all8_reads", pass_rd, NCH);
      end

      // Noise channel follows LFSR bit 0 from the seed
      do_reset();
      set_ch(3, 15, 1, 0, 1);
      lf = 15'h0001;
      for (int p = 0; p < 16; p++) begin
         wait_stb();
         check($sformatf("noise_p%0d_sout", p), sout, lf[0] ? 28 : 0);
         check($sformatf("noise_p%0d_reads", p), pass_rd, NCH-1);
         lf = {lf[13:0], lf[14] ^ lf[13]};
      end

      // Output gate: phase keeps stepping while muted
      do_reset();
      set_ch(0, 15, 'h08000, 0, 0);
      for (int p = 0; p < 6; p++) begin
         snd_en = (p == 2 || p == 3) ? 1'b0 : 1'b1;
         wait_stb();
         check($sformatf("gate_p%0d_sout", p), sout, snd_en ? 28 : 0);
         check($sformatf("gate_p%0d_ad", p), pass_ad0, p);
      end
      snd_en = 1'b1;

      // Frequency write to ch0 during ch5 ACC applies from the next period
      do_reset();
      set_ch(0, 15, 'h08000, 0, 0);
      wait_stb();
      check("late_p0_ad", pass_ad0, 0);
      n = 0;
      k = 0;
      while (n < 6 && k < 4*CLKDIV) begin
         @(negedge clk);
         k++;
         if (wave_rd) n++;
      end
      check("late_find_ch5", n, 6);
      @(negedge clk);
      @(negedge clk);
      wr(0, 6, 8'h01);
      wait_stb();
      check("late_p1_ad", pass_ad0, 1);
      check("late_p1_sout", sout, 28);
      wait_stb();
      check("late_p2_ad", pass_ad0, 2);
      wait_stb();
      check("late_p3_ad", pass_ad0, 5);

      // Reset in the middle of a pass
      n = 0;
      while (!wave_rd && n < 4*CLKDIV) begin
         @(negedge clk);
         n++;
      end
      check("pre_rst_rd", wave_rd, 1);
      check("pre_rst_ad", wave_ad, 8);
      check("pre_rst_sout", sout, 28);
      rst = 1'b1;
      #1;
      check("midrst_sout", sout, 0);
      check("midrst_stb", stb, 0);
      check("midrst_rd", wave_rd, 0);
      check("midrst_ad", wave_ad, 0);
      @(negedge clk);
      @(negedge clk);
      rst    = 1'b0;
      rd_cnt = 0;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!stb && k < 4*CLKDIV);
      check("rst_to_stb_cycles", k, RST_LAT);
      check("post_rst_sout", sout, 0);

      // Sixteen channels at full scale saturate the output
      @(negedge clk);
      for (int c = 0; c < 16; c++) begin
         wr16(c, 3, 15);
         wr16(c, 4, 1);
      end
      wait_stb16();
      wait_stb16();
      for (int p = 0; p < 2; p++) begin
         wait_stb16();
         check("nch16_sat_sout", sout16, 255);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
